// File: rtl/display_scan_ctrl_if.sv
// Bus between the scan controller and its host/driver: shadow-load inputs and scan outputs.
interface display_scan_ctrl_if;
    localparam int unsigned VALUE_W = 12;
    localparam int unsigned DIGITS  = 3;
    localparam int unsigned NIB_W   = 4;
    localparam int unsigned SEL_W   = 2;

    logic [VALUE_W-1:0] value_in;
    logic [DIGITS-1:0]  dp_in;
    logic               load_in;
    logic               lz_blank_in;
    logic [SEL_W-1:0]   en_out;
    logic [NIB_W-1:0]   display_out;
    logic               dp_out;
    logic               frame_done;

    // Host side: supplies data and load strobe, observes scan outputs.
    modport master (
        output value_in, dp_in, load_in, lz_blank_in,
        input  en_out, display_out, dp_out, frame_done
    );

    // Controller side.
    modport slave (
        input  value_in, dp_in, load_in, lz_blank_in,
        output en_out, display_out, dp_out, frame_done
    );
endinterface

// File: rtl/display_scan_ctrl.sv
// Time-multiplexed 3-digit 7-segment scan controller with per-slot blanking gap,
// frame-synchronous (tear-free) value updates and optional leading-zero blanking.
module display_scan_ctrl #(
    parameter int unsigned CLK_DIV      = 50000,
    parameter int unsigned BLANK_CYCLES = 16
) (
    input  logic                clock,
    input  logic                reset_n,
    display_scan_ctrl_if.slave  bus
);
    localparam int unsigned PW      = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int unsigned VALUE_W = 12;
    localparam int unsigned DIGITS  = 3;
    localparam int unsigned NIB_W   = 4;
    localparam int unsigned SEL_W   = 2;

    localparam logic [PW-1:0]    PRESC_LAST = PW'(CLK_DIV - 1);
    localparam logic [SEL_W-1:0] IDX_LAST   = SEL_W'(2);
    localparam logic [SEL_W-1:0] BLANK_SEL  = SEL_W'(3);

    logic [PW-1:0]      prescaler;
    logic [SEL_W-1:0]   index;
    logic [VALUE_W-1:0] shadow_value;
    logic [DIGITS-1:0]  shadow_dp;
    logic               pending;
    logic [VALUE_W-1:0] active_value;
    logic [DIGITS-1:0]  active_dp;

    logic               slot_end_c;
    logic               frame_wrap_c;
    logic               in_gap_c;
    logic               lz_c;
    logic               blank_c;
    logic [NIB_W-1:0]   nibble_c;
    logic               dp_sel_c;

    assign slot_end_c   = (prescaler == PRESC_LAST);
    assign frame_wrap_c = slot_end_c && (index == IDX_LAST);

    // Anti-ghosting gap at the start of every slot; absent entirely when BLANK_CYCLES is 0.
    generate
        if (BLANK_CYCLES == 0) begin : g_no_gap
            assign in_gap_c = 1'b0;
        end else begin : g_gap
            assign in_gap_c = (prescaler < PW'(BLANK_CYCLES));
        end
    endgenerate

    // Digit 0 is never suppressed so a zero value still shows a single "0".
    assign lz_c = bus.lz_blank_in &&
                  (((index == SEL_W'(2)) && (active_value[11:8] == 4'h0)) ||
                   ((index == SEL_W'(1)) && (active_value[11:4] == 8'h00)));

    assign blank_c = in_gap_c || lz_c;

    // Select nibble and decimal point of the digit currently being scanned.
    always_comb begin
        nibble_c = active_value[3:0];
        dp_sel_c = active_dp[0];
        case (index)
            SEL_W'(1): begin
                nibble_c = active_value[7:4];
                dp_sel_c = active_dp[1];
            end
            SEL_W'(2): begin
                nibble_c = active_value[11:8];
                dp_sel_c = active_dp[2];
            end
            default: begin
                nibble_c = active_value[3:0];
                dp_sel_c = active_dp[0];
            end
        endcase
    end

    // Slot prescaler and digit index.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            prescaler <= '0;
            index     <= '0;
        end else if (slot_end_c) begin
            prescaler <= '0;
            index     <= (index == IDX_LAST) ? '0 : index + SEL_W'(1);
        end else begin
            prescaler <= prescaler + PW'(1);
        end
    end

    // Shadow capture and frame-boundary transfer; a load on the wrap edge itself uses live inputs.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            shadow_value <= '0;
            shadow_dp    <= '0;
            pending      <= 1'b0;
            active_value <= '0;
            active_dp    <= '0;
        end else begin
            if (bus.load_in) begin
                shadow_value <= bus.value_in;
                shadow_dp    <= bus.dp_in;
            end
            if (frame_wrap_c) begin
                pending <= 1'b0;
                if (bus.load_in) begin
                    active_value <= bus.value_in;
                    active_dp    <= bus.dp_in;
                end else if (pending) begin
                    active_value <= shadow_value;
                    active_dp    <= shadow_dp;
                end
            end else if (bus.load_in) begin
                pending <= 1'b1;
            end
        end
    end

    // Registered driver outputs, one cycle behind the scan state.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            bus.en_out      <= BLANK_SEL;
            bus.display_out <= '0;
            bus.dp_out      <= 1'b0;
            bus.frame_done  <= 1'b0;
        end else begin
            bus.en_out      <= blank_c ? BLANK_SEL : index;
            bus.display_out <= nibble_c;
            bus.dp_out      <= blank_c ? 1'b0 : dp_sel_c;
            bus.frame_done  <= frame_wrap_c;
        end
    end
endmodule

// File: tb/tb_display_scan_ctrl.sv
// Directed bench for display_scan_ctrl: CLK_DIV=8 with BLANK_CYCLES=2 and 0.
module tb_display_scan_ctrl;
    logic clock = 1'b0;
    logic reset_n;
    int   n_checks = 0;
    int   n_fail   = 0;

    always #5 clock = ~clock;

    display_scan_ctrl_if bus1 ();
    display_scan_ctrl_if bus2 ();

    display_scan_ctrl #(.CLK_DIV(8), .BLANK_CYCLES(2)) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus1.slave)
    );

    display_scan_ctrl #(.CLK_DIV(8), .BLANK_CYCLES(0)) dut_nogap (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus2.slave)
    );

    task automatic check_eq(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Expected {en, nibble, dp} at frame offset k (pre-edge prescaler k%8, index k/8).
    function automatic logic [6:0] model(input int k, input logic [11:0] v, input logic [2:0] d,
                                         input logic lz, input int blank);
        int pres = k % 8;
        int idx  = k / 8;
        logic [3:0] nib;
        logic bl;
        nib = 4'(v >> (4 * idx));
        bl  = (pres < blank) ||
              (lz && (idx == 2) && (v[11:8] == 4'h0)) ||
              (lz && (idx == 1) && (v[11:4] == 8'h00));
        return bl ? {2'd3, nib, 1'b0} : {2'(idx), nib, d[idx]};
    endfunction

    // Runs nk edges of a frame whose active data is v/d, optionally pulsing load at offsets la1/la2.
    task automatic run_frame(input logic [11:0] v, input logic [2:0] d, input logic lz, input int nk,
                             input int la1, input logic [11:0] lv1, input logic [2:0] ld1,
                             input int la2, input logic [11:0] lv2, input logic [2:0] ld2);
        logic [6:0] e;
        logic [6:0] e2;
        bus1.lz_blank_in = lz;
        for (int k = 0; k < nk; k++) begin
            bus1.load_in  = (k == la1) || (k == la2);
            bus1.value_in = (k == la2) ? lv2 : lv1;
            bus1.dp_in    = (k == la2) ? ld2 : ld1;
            tick();
            bus1.load_in  = 1'b0;
            bus1.value_in = 12'hBAD;
            bus1.dp_in    = 3'b111;
            e  = model(k, v, d, lz, 2);
            e2 = model(k, 12'h000, 3'b000, 1'b0, 0);
            check_eq("en_out", 16'(bus1.en_out), 16'(e[6:5]));
            check_eq("dp_out", 16'(bus1.dp_out), 16'(e[0]));
            if (e[6:5] != 2'd3)
                check_eq("display_out", 16'(bus1.display_out), 16'(e[4:1]));
            check_eq("frame_done", 16'(bus1.frame_done), 16'(k == 23));
            check_eq("en_out_nogap", 16'(bus2.en_out), 16'(e2[6:5]));
            check_eq("frame_done_nogap", 16'(bus2.frame_done), 16'(k == 23));
        end
    endtask

    task automatic check_reset_state(input string where);
        check_eq({where, " en_out"}, 16'(bus1.en_out), 16'd3);
        check_eq({where, " display_out"}, 16'(bus1.display_out), 16'd0);
        check_eq({where, " dp_out"}, 16'(bus1.dp_out), 16'd0);
        check_eq({where, " frame_done"}, 16'(bus1.frame_done), 16'd0);
        check_eq({where, " en_out_nogap"}, 16'(bus2.en_out), 16'd3);
    endtask

    initial begin
        reset_n          = 1'b0;
        bus1.value_in    = '0;
        bus1.dp_in       = '0;
        bus1.load_in     = 1'b0;
        bus1.lz_blank_in = 1'b0;
        bus2.value_in    = '0;
        bus2.dp_in       = '0;
        bus2.load_in     = 1'b0;
        bus2.lz_blank_in = 1'b0;

        repeat (3) tick();
        check_reset_state("reset");
        reset_n = 1'b1;

        // Mid-frame load shows only from the next frame.
        run_frame(12'h000, 3'b000, 1'b0, 24, 12, 12'hA5C, 3'b010, -1, 12'h000, 3'b000);
        // Two loads in one frame: last wins.
        run_frame(12'hA5C, 3'b010, 1'b0, 24, 3, 12'h111, 3'b001, 15, 12'h222, 3'b100);
        // Load exactly on the wrap edge takes effect immediately.
        run_frame(12'h222, 3'b100, 1'b0, 24, 23, 12'h333, 3'b011, -1, 12'h000, 3'b000);
        run_frame(12'h333, 3'b011, 1'b0, 24, 5, 12'h007, 3'b000, -1, 12'h000, 3'b000);
        // Leading-zero blanking.
        run_frame(12'h007, 3'b000, 1'b1, 24, 5, 12'h000, 3'b000, -1, 12'h000, 3'b000);
        run_frame(12'h000, 3'b000, 1'b1, 24, 5, 12'h050, 3'b000, -1, 12'h000, 3'b000);
        // Stop mid-slot of digit 1 with a load pending, then reset asynchronously.
        run_frame(12'h050, 3'b000, 1'b1, 12, 2, 12'h123, 3'b111, -1, 12'h000, 3'b000);
        #2;
        reset_n = 1'b0;
        #1;
        check_reset_state("async_reset");
        repeat (2) tick();
        check_reset_state("held_reset");
        reset_n = 1'b1;
        bus1.lz_blank_in = 1'b0;

        // Scan restarts at digit 0 with cleared data; the pending load is gone.
        run_frame(12'h000, 3'b000, 1'b0, 24, -1, 12'h000, 3'b000, -1, 12'h000, 3'b000);
        run_frame(12'h000, 3'b000, 1'b0, 24, -1, 12'h000, 3'b000, -1, 12'h000, 3'b000);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
